tape_save_buffer: RTL and testbench

TAPE_SAVE_BUFFER -- requirements
Module: tape_save_buffer

---
 rtl/tape_save_buffer.sv | 156 +++++++++++++++
 tb/tb_tape_save_buffer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/tape_save_buffer.sv
// Capture buffer for bytes leaving the ACIA transmitter, read back by the HPS as a tape save image.
// Optional macro TAPE_SAVE_FILTER_EN: strip bit 7 and drop NUL/DEL bytes before storing.
module tape_save_buffer #(
    parameter int          ADDR_W   = 12,
    parameter logic [7:0]  EOF_BYTE = 8'h1A
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              arm,
    input  logic              stop,
    input  logic [7:0]        cap_data,
    input  logic              cap_valid,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [15:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic [ADDR_W:0]   save_len,
    output logic              capturing,
    output logic              overflow
);

    localparam int DEPTH = 32'd1 << ADDR_W;
    localparam int CMP_W = (ADDR_W + 1 > 16) ? ADDR_W + 1 : 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        UPLOAD  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [ADDR_W:0]     save_len_r;
    logic [ADDR_W:0]     save_len_next_s;
    logic                overflow_r;
    logic                overflow_next_s;
    logic                capturing_r;
    logic                wr_en_s;
    logic                rd_en_s;
    logic                in_range_s;
    logic [ADDR_W-1:0]   ram_addr_s;
    logic [7:0]          byte_s;
    logic                keep_s;
    logic [7:0]          ram_r [DEPTH];
    logic [7:0]          ram_q_r;
    logic                din_valid_r;
    logic                eof_sel_r;

    // Incoming byte conditioning (optional filter)
    always_comb begin
`ifdef TAPE_SAVE_FILTER_EN
        byte_s = {1'b0, cap_data[6:0]};
        keep_s = (byte_s != 8'h00) && (byte_s != 8'h7F);
`else
        byte_s = cap_data;
        keep_s = 1'b1;
`endif
    end

    // Next-state and capture bookkeeping; upload overrides everything, then arm, stop, cap_valid
    always_comb begin
        state_next_s    = state_r;
        save_len_next_s = save_len_r;
        overflow_next_s = overflow_r;
        wr_en_s         = 1'b0;
        if (ioctl_upload) begin
            state_next_s = UPLOAD;
        end else begin
            case (state_r)
                IDLE: begin
                    if (arm) begin
                        state_next_s    = CAPTURE;
                        save_len_next_s = {(ADDR_W+1){1'b0}};
                        overflow_next_s = 1'b0;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                CAPTURE: begin
                    if (arm) begin
                        state_next_s    = CAPTURE;
                        save_len_next_s = {(ADDR_W+1){1'b0}};
                        overflow_next_s = 1'b0;
                    end else if (stop) begin
                        state_next_s = IDLE;
                    end else if (cap_valid && keep_s) begin
                        // Top bit of save_len set means every RAM slot is used
                        if (save_len_r[ADDR_W]) begin
                            overflow_next_s = 1'b1;
                        end else begin
                            wr_en_s         = 1'b1;
                            save_len_next_s = save_len_r + {{ADDR_W{1'b0}}, 1'b1};
                        end
                    end else begin
                        state_next_s = CAPTURE;
                    end
                end
                UPLOAD: begin
                    state_next_s = IDLE;
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

    // Read qualification and shared RAM address (write in CAPTURE, read in UPLOAD)
    always_comb begin
        rd_en_s    = (state_r == UPLOAD) && ioctl_rd;
        in_range_s = CMP_W'(ioctl_addr) < CMP_W'(save_len_r);
        if (state_r == CAPTURE) begin
            ram_addr_s = save_len_r[ADDR_W-1:0];
        end else begin
            ram_addr_s = ioctl_addr[ADDR_W-1:0];
        end
    end

    // Single-port block RAM; no reset so it maps onto RAM primitives
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            ram_r[ram_addr_s] <= byte_s;
        end
        if (rd_en_s) begin
            ram_q_r <= ram_r[ram_addr_s];
        end
    end

    // Control state, counters and read-path selectors
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_r     <= IDLE;
            save_len_r  <= {(ADDR_W+1){1'b0}};
            overflow_r  <= 1'b0;
            capturing_r <= 1'b0;
            din_valid_r <= 1'b0;
            eof_sel_r   <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            save_len_r  <= save_len_next_s;
            overflow_r  <= overflow_next_s;
            capturing_r <= (state_next_s == CAPTURE);
            if (rd_en_s) begin
                din_valid_r <= 1'b1;
                eof_sel_r   <= ~in_range_s;
            end
        end
    end

    // Read data is held by ram_q_r/eof_sel_r until the next accepted read
    assign ioctl_din = din_valid_r ? (eof_sel_r ? EOF_BYTE : ram_q_r) : 8'h00;
    assign save_len  = save_len_r;
    assign capturing = capturing_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_tape_save_buffer.sv
// Self-checking bench for tape_save_buffer (ADDR_W=4) using an expected-read-data queue.
module tb_tape_save_buffer;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          n_reset = 1'b0;
    logic          arm = 1'b0;
    logic          stop = 1'b0;
    logic [7:0]    cap_data = 8'h00;
    logic          cap_valid = 1'b0;
    logic          ioctl_upload = 1'b0;
    logic          ioctl_rd = 1'b0;
    logic [15:0]   ioctl_addr = 16'h0000;
    logic [7:0]    ioctl_din;
    logic [AW:0]   save_len;
    logic          capturing;
    logic          overflow;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [7:0]    exp_q[$];
    logic [7:0]    exp_b;

    tape_save_buffer #(.ADDR_W(AW), .EOF_BYTE(8'h1A)) dut (
        .clk(clk), .n_reset(n_reset), .arm(arm), .stop(stop),
        .cap_data(cap_data), .cap_valid(cap_valid),
        .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
        .ioctl_din(ioctl_din), .save_len(save_len), .capturing(capturing), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Stimulus steps: inputs change at negedge, DUT samples at posedge
    task automatic do_arm();
        arm = 1'b1; @(negedge clk); arm = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1; @(negedge clk); stop = 1'b0;
    endtask

    task automatic cap(input logic [7:0] b);
        cap_data = b; cap_valid = 1'b1; @(negedge clk); cap_valid = 1'b0;
    endtask

    task automatic upload_on();
        ioctl_upload = 1'b1; @(negedge clk);
    endtask

    task automatic upload_off();
        ioctl_upload = 1'b0; @(negedge clk);
    endtask

    task automatic issue_rd(input logic [15:0] a, input logic [7:0] e);
        ioctl_addr = a; ioctl_rd = 1'b1; exp_q.push_back(e);
        @(negedge clk);
        ioctl_rd = 1'b0;
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (ioctl_din !== 8'h00) begin n_fail++; $display("FAIL reset_din got %h want 00", ioctl_din); end
        n_checks++; if (save_len !== 5'd0) begin n_fail++; $display("FAIL reset_len got %0d want 0", save_len); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow); end
        n_checks++; if (capturing !== 1'b0) begin n_fail++; $display("FAIL reset_cap got %b want 0", capturing); end
        n_reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] data[4] = '{8'h31, 8'h30, 8'h0D, 8'h0A};
        do_arm();
        n_checks++; if (capturing !== 1'b1) begin n_fail++; $display("FAIL basic_capturing got %b want 1", capturing); end
        for (int i = 0; i < 4; i++) cap(data[i]);
        do_stop();
        n_checks++; if (capturing !== 1'b0) begin n_fail++; $display("FAIL basic_stopped got %b want 0", capturing); end
        n_checks++; if (save_len !== 5'd4) begin n_fail++; $display("FAIL basic_len got %0d want 4", save_len); end
        upload_on();
        for (int i = 0; i < 5; i++) begin
            issue_rd(16'(i), (i < 4) ? data[i] : 8'h1A);
            exp_b = exp_q.pop_front();
            n_checks++; if (ioctl_din !== exp_b) begin n_fail++; $display("FAIL basic_rd%0d got %h want %h", i, ioctl_din, exp_b); end
        end
        issue_rd(16'h0100, 8'h1A);
        exp_b = exp_q.pop_front();
        n_checks++; if (ioctl_din !== exp_b) begin n_fail++; $display("FAIL basic_rd_far got %h want %h", ioctl_din, exp_b); end
        issue_rd(16'h0001, 8'h30);
        repeat (3) @(negedge clk);
        exp_b = exp_q.pop_front();
        n_checks++; if (ioctl_din !== exp_b) begin n_fail++; $display("FAIL basic_hold got %h want %h", ioctl_din, exp_b); end
        n_checks++; if (save_len !== 5'd4) begin n_fail++; $display("FAIL basic_len_upload got %0d want 4", save_len); end
        upload_off();
    endtask

    task automatic test_rd_outside_upload();
        issue_rd(16'h0002, 8'h30);
        exp_b = exp_q.pop_front();
        n_checks++; if (ioctl_din !== exp_b) begin n_fail++; $display("FAIL idle_rd got %h want %h", ioctl_din, exp_b); end
    endtask

    task automatic test_filter();
        logic [7:0] in_b[4] = '{8'hC1, 8'h00, 8'h7F, 8'h42};
`ifdef TAPE_SAVE_FILTER_EN
        logic [7:0] st_b[2] = '{8'h41, 8'h42};
        int n = 2;
`else
        logic [7:0] st_b[4] = '{8'hC1, 8'h00, 8'h7F, 8'h42};
        int n = 4;
`endif
        do_arm();
        for (int i = 0; i < 4; i++) cap(in_b[i]);
        do_stop();
        n_checks++; if (save_len !== 5'(n)) begin n_fail++; $display("FAIL filter_len got %0d want %0d", save_len, n); end
        upload_on();
        for (int i = 0; i < n; i++) begin
            issue_rd(16'(i), st_b[i]);
            exp_b = exp_q.pop_front();
            n_checks++; if (ioctl_din !== exp_b) begin n_fail++; $display("FAIL filter_rd%0d got %h want %h", i, ioctl_din, exp_b); end
        end
        upload_off();
    endtask

    task automatic test_overflow();
        do_arm();
        for (int i = 0; i < 16; i++) cap(8'h41);
        n_checks++; if (save_len !== 5'd16) begin n_fail++; $display("FAIL ovf_len16 got %0d want 16", save_len); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b want 0", overflow); end
        cap(8'h41);
        n_checks++; if (save_len !== 5'd16) begin n_fail++; $display("FAIL ovf_len17 got %0d want 16", save_len); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
        do_stop();
        upload_on();
        issue_rd(16'd15, 8'h41);
        exp_b = exp_q.pop_front();
        n_checks++; if (ioctl_din !== exp_b) begin n_fail++; $display("FAIL ovf_rd15 got %h want %h", ioctl_din, exp_b); end
        issue_rd(16'd16, 8'h1A);
        exp_b = exp_q.pop_front();
        n_checks++; if (ioctl_din !== exp_b) begin n_fail++; $display("FAIL ovf_rd16 got %h want %h", ioctl_din, exp_b); end
        upload_off();
        do_arm();
        n_checks++; if (overflow !== 1'b0 || save_len !== 5'd0) begin n_fail++; $display("FAIL ovf_rearm got ovf=%b len=%0d want 0/0", overflow, save_len); end
        do_stop();
    endtask

    task automatic test_arm_collide();
        arm = 1'b1; cap_data = 8'h55; cap_valid = 1'b1;
        @(negedge clk);
        arm = 1'b0; cap_valid = 1'b0;
        cap(8'h66);
        do_stop();
        n_checks++; if (save_len !== 5'd1) begin n_fail++; $display("FAIL collide_len got %0d want 1", save_len); end
        upload_on();
        issue_rd(16'd0, 8'h66);
        exp_b = exp_q.pop_front();
        n_checks++; if (ioctl_din !== exp_b) begin n_fail++; $display("FAIL collide_rd0 got %h want %h", ioctl_din, exp_b); end
        issue_rd(16'd1, 8'h1A);
        exp_b = exp_q.pop_front();
        n_checks++; if (ioctl_din !== exp_b) begin n_fail++; $display("FAIL collide_rd1 got %h want %h", ioctl_din, exp_b); end
        upload_off();
    endtask

    task automatic test_upload_abort();
        do_arm();
        cap(8'h01); cap(8'h02); cap(8'h03);
        upload_on();
        n_checks++; if (capturing !== 1'b0) begin n_fail++; $display("FAIL abort_cap got %b want 0", capturing); end
        upload_off();
        cap(8'h04);
        n_checks++; if (save_len !== 5'd3) begin n_fail++; $display("FAIL abort_len got %0d want 3", save_len); end
        n_checks++; if (capturing !== 1'b0) begin n_fail++; $display("FAIL abort_idle got %b want 0", capturing); end
    endtask

    task automatic test_async_reset();
        upload_on();
        issue_rd(16'd1, 8'h02);
        exp_b = exp_q.pop_front();
        n_checks++; if (ioctl_din !== exp_b) begin n_fail++; $display("FAIL areset_pre got %h want %h", ioctl_din, exp_b); end
        @(posedge clk);
        #2;
        n_reset = 1'b0;
        ioctl_upload = 1'b0;
        #1;
        n_checks++; if (ioctl_din !== 8'h00 || save_len !== 5'd0 || overflow !== 1'b0 || capturing !== 1'b0) begin
            n_fail++; $display("FAIL areset_now got din=%h len=%0d ovf=%b cap=%b want 00/0/0/0", ioctl_din, save_len, overflow, capturing);
        end
        @(negedge clk);
        n_reset = 1'b1;
        do_arm();
        n_checks++; if (capturing !== 1'b1) begin n_fail++; $display("FAIL areset_first_arm got %b want 1", capturing); end
        do_stop();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rd_outside_upload();
        test_filter();
        test_overflow();
        test_arm_collide();
        test_upload_abort();
        test_async_reset();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL queue_drain got %0d want 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
